// File: rtl/m12_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : m12_tdm_demux
// Brief    : Registered 1:2 TDM demultiplexer with frame alignment tracking,
//            framing-error strobe and completed-frame counter. Optional WAIT1
//            stall timeout enabled by defining M12_DEMUX_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module m12_tdm_demux #(
    parameter int WIDTH   = 1,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sync,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic             out_valid,
    output logic             sel,
    output logic             sync_err,
    output logic [7:0]       frame_cnt
);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        WAIT1 = 2'd1,
        WAIT0 = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hold0;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("m12_tdm_demux: TIMEOUT must be at least 2");
    end

`ifdef M12_DEMUX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] stall_cnt;
    logic          stall_hit;

    // Fires on the idle cycle that brings the consecutive-stall count to TIMEOUT
    assign stall_hit = (stall_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (in_valid || (state != WAIT1) || stall_hit) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            hold0     <= '0;
            out0      <= '0;
            out1      <= '0;
            out_valid <= 1'b0;
            sel       <= 1'b0;
            sync_err  <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        if (in_sync) begin
                            hold0 <= in_data;
                            state <= WAIT1;
                            sel   <= 1'b1;
                        end
                    end
                    WAIT1: begin
                        if (in_sync) begin
                            // A fresh slot 0 restarts the frame in place
                            sync_err <= 1'b1;
                            hold0    <= in_data;
                        end else begin
                            out0      <= hold0;
                            out1      <= in_data;
                            out_valid <= 1'b1;
                            frame_cnt <= frame_cnt + 8'd1;
                            state     <= WAIT0;
                            sel       <= 1'b0;
                        end
                    end
                    WAIT0: begin
                        if (in_sync) begin
                            hold0 <= in_data;
                            state <= WAIT1;
                            sel   <= 1'b1;
                        end else begin
                            sync_err <= 1'b1;
                            state    <= HUNT;
                        end
                    end
                    default: begin
                        state <= HUNT;
                        sel   <= 1'b0;
                    end
                endcase
            end
`ifdef M12_DEMUX_TIMEOUT_EN
            else if ((state == WAIT1) && stall_hit) begin
                sync_err <= 1'b1;
                state    <= HUNT;
                sel      <= 1'b0;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m12_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_m12_tdm_demux
// Brief    : Directed self-checking bench for m12_tdm_demux against a
//            slot-level behavioural model. Honours M12_DEMUX_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module tb_m12_tdm_demux;

    localparam int W  = 1;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_sync;
    logic [W-1:0] in_data;
    logic [W-1:0] out0;
    logic [W-1:0] out1;
    logic         out_valid;
    logic         sel;
    logic         sync_err;
    logic [7:0]   frame_cnt;

    m12_tdm_demux #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sync   (in_sync),
        .in_data   (in_data),
        .out0      (out0),
        .out1      (out1),
        .out_valid (out_valid),
        .sel       (sel),
        .sync_err  (sync_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slot-level model: a pending slot-0 value and whether the stream is aligned
    bit     have_s0;
    int     s0_val;
    bit     aligned;
    int     idle_run;
    int     e_out0, e_out1, e_cnt;
    bit     e_valid, e_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        have_s0 = 0; s0_val = 0; aligned = 0; idle_run = 0;
        e_out0 = 0; e_out1 = 0; e_cnt = 0; e_valid = 0; e_err = 0;
    endtask

    task automatic model_step(input bit v, input bit s, input int d);
        e_valid = 0;
        e_err   = 0;
        if (v) begin
            idle_run = 0;
            if (have_s0) begin
                if (s) begin
                    e_err  = 1;
                    s0_val = d;
                end else begin
                    e_out0  = s0_val;
                    e_out1  = d;
                    e_valid = 1;
                    e_cnt   = (e_cnt + 1) % 256;
                    have_s0 = 0;
                    aligned = 1;
                end
            end else if (s) begin
                have_s0 = 1;
                s0_val  = d;
            end else if (aligned) begin
                e_err   = 1;
                aligned = 0;
            end
        end else begin
`ifdef M12_DEMUX_TIMEOUT_EN
            if (have_s0) begin
                idle_run++;
                if (idle_run == TO) begin
                    e_err    = 1;
                    have_s0  = 0;
                    aligned  = 0;
                    idle_run = 0;
                end
            end else begin
                idle_run = 0;
            end
`endif
        end
    endtask

    task automatic compare_all();
        chk("out0",      32'(out0),      32'(e_out0));
        chk("out1",      32'(out1),      32'(e_out1));
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("sel",       32'(sel),       32'(have_s0));
        chk("sync_err",  32'(sync_err),  32'(e_err));
        chk("frame_cnt", 32'(frame_cnt), 32'(e_cnt));
    endtask

    task automatic beat(input bit v, input bit s, input int d);
        in_valid = v;
        in_sync  = s;
        in_data  = W'(d);
        @(posedge clk);
        model_step(v, s, d);
        @(negedge clk);
        compare_all();
    endtask

    int nvalid;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sync = 1'b0; in_data = '0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // First beat after release: sync=0 is discarded silently
        beat(1, 0, 1);
        chk("first_err_lit", 32'(sync_err), 32'd0);

        // Basic frames
        beat(1, 1, 0);
        chk("basic_sel_lit", 32'(sel), 32'd1);
        beat(1, 0, 1);
        chk("basic_out0_lit", 32'(out0), 32'd0);
        chk("basic_out1_lit", 32'(out1), 32'd1);
        chk("basic_valid_lit", 32'(out_valid), 32'd1);
        chk("basic_cnt_lit", 32'(frame_cnt), 32'd1);
        beat(0, 0, 0);
        chk("valid_drop_lit", 32'(out_valid), 32'd0);
        beat(1, 1, 1);
        beat(1, 0, 1);
        chk("frame2_out0_lit", 32'(out0), 32'd1);
        chk("frame2_cnt_lit", 32'(frame_cnt), 32'd2);

        // Stall inside a frame
        beat(1, 1, 1);
        repeat (5) beat(0, 0, 0);
        chk("stall_sel_lit", 32'(sel), 32'd1);
        beat(1, 0, 0);
        chk("stall_out0_lit", 32'(out0), 32'd1);
        chk("stall_out1_lit", 32'(out1), 32'd0);
        chk("stall_cnt_lit", 32'(frame_cnt), 32'd3);

        // Framing error while expecting slot 1
        beat(1, 1, 1);
        beat(1, 1, 0);
        chk("w1err_lit", 32'(sync_err), 32'd1);
        chk("w1err_out1_lit", 32'(out1), 32'd0);
        beat(1, 0, 1);
        chk("w1err_out0_lit", 32'(out0), 32'd0);
        chk("w1err_out1b_lit", 32'(out1), 32'd1);
        chk("w1err_cnt_lit", 32'(frame_cnt), 32'd4);

        // Framing error while expecting slot 0
        beat(1, 0, 0);
        chk("w0err_lit", 32'(sync_err), 32'd1);
        chk("w0err_out1_lit", 32'(out1), 32'd1);
        beat(1, 0, 1);
        chk("hunt_quiet_lit", 32'(sync_err), 32'd0);

        // Long stall: times out only when the feature is built in
        beat(1, 1, 1);
        repeat (TO) beat(0, 0, 0);
`ifdef M12_DEMUX_TIMEOUT_EN
        chk("timeout_err_lit", 32'(sync_err), 32'd1);
        beat(1, 0, 0);
        chk("timeout_hunt_lit", 32'(out_valid), 32'd0);
`else
        chk("no_timeout_lit", 32'(sync_err), 32'd0);
        beat(1, 0, 0);
        chk("late_frame_lit", 32'(out_valid), 32'd1);
        chk("late_cnt_lit", 32'(frame_cnt), 32'd5);
`endif

        // Asynchronous reset mid-frame
        beat(1, 1, 1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_sel_lit", 32'(sel), 32'd0);
        chk("rst_cnt_lit", 32'(frame_cnt), 32'd0);
        compare_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        beat(1, 0, 1);
        chk("rst_lost_lit", 32'(out_valid), 32'd0);
        chk("rst_noerr_lit", 32'(sync_err), 32'd0);

        // 256 back-to-back frames wrap the counter
        nvalid = 0;
        for (int i = 0; i < 256; i++) begin
            beat(1, 1, i & 1);
            beat(1, 0, (i >> 1) & 1);
            if (out_valid === 1'b1) nvalid++;
        end
        chk("wrap_cnt_lit", 32'(frame_cnt), 32'd0);
        chk("wrap_valids_lit", 32'(nvalid), 32'd256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/m12_tdm_demux.md
# m12_tdm_demux

Registered 1:2 time-division demultiplexer that is the receive end of the 2:1 multiplexer path. It accepts a slot-interleaved stream, where slot 0 is marked by `in_sync`, and splits each slot-0/slot-1 pair back into two parallel channels. Each reconstructed pair is presented with a one-cycle valid strobe. It tracks frame alignment with a small state machine, flags framing errors and counts completed frames.

## Interface
- `WIDTH`, 1: data width of each slot and each output channel.
- `TIMEOUT`, 16: stall limit in cycles. Used only when `M12_DEMUX_TIMEOUT_EN` is defined; must be ≥ 2.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_data` / `in_sync` carry a slot this cycle.
- `in_sync` input 1: qualifies the current slot as slot 0 (frame start).
- `in_data` input WIDTH: slot payload.
- `out0` output WIDTH: slot-0 value of the last completed frame.
- `out1` output WIDTH: slot-1 value of the last completed frame.
- `out_valid` output 1: one-cycle strobe; `out0`/`out1` just updated.
- `sel` output 1: slot expected next (0 = slot 0, 1 = slot 1).
- `sync_err` output 1: one-cycle strobe on a framing error.
- `frame_cnt` output 8: completed frames, wraps 255→0.

## Operation
- Holding register `hold0[WIDTH]` stores the slot-0 value of the frame in progress.
- FSM states:
  - `HUNT`: reset state; discards slots until aligned.
  - `WAIT1`: slot 0 captured, expecting slot 1.
  - `WAIT0`: aligned, expecting slot 0.
- `in_valid`=0 is a stall in every state: no state change and no strobes.
- Transitions, evaluated on beats where `in_valid`=1:
  - HUNT, sync=1: `hold0`←`in_data`, go to WAIT1.
  - HUNT, sync=0: discard the slot, stay in HUNT, no error.
  - WAIT1, sync=0: `out0`←`hold0`, `out1`←`in_data`, `out_valid`=1, `frame_cnt`+1, go to WAIT0.
  - WAIT1, sync=1: `sync_err`=1; `hold0`←`in_data` (the new frame restarts); stay in WAIT1.
  - WAIT0, sync=1: `hold0`←`in_data`, go to WAIT1.
  - WAIT0, sync=0: `sync_err`=1, slot discarded, go to HUNT.
- `sel`=1 in WAIT1, 0 otherwise.
- `out0`/`out1` hold their value until the next completed frame. A `sync_err` never alters them.
- `frame_cnt` is modulo 256 and is not cleared by `sync_err`.

## Timing
- Reset (`rst_n`=0, takes effect immediately, no clock needed):
  - state HUNT;
  - `hold0`, `out0`, `out1`, `frame_cnt` = 0;
  - `out_valid`, `sync_err`, `sel` = 0.
- All outputs are registered; there are no combinational paths from input to output.
- Latency:
  - `out_valid`, `out0`, `out1` and `frame_cnt` update at the clock edge that accepts the slot-1 beat. They are visible one cycle after that beat is presented.
  - `sync_err` follows the same timing, asserted for exactly one cycle per offending beat.
- Back-to-back frames (valid every cycle, alternating sync 1,0) give `out_valid` every second cycle, with no bubbles.
- Reset mid-frame: a partially captured `hold0` is lost, and no `out_valid` is generated for that frame.
- Reset deassertion is synchronised externally; the first edge after release is evaluated normally.

## Configuration
- `M12_DEMUX_TIMEOUT_EN` defined:
  - A stall counter counts consecutive `in_valid`=0 cycles while in WAIT1; any beat clears it.
  - Reaching `TIMEOUT` gives `sync_err`=1 for one cycle and a transition to HUNT, with `hold0` kept.
  - The counter is reset to 0 by `rst_n`.
- Not defined: no counter is instantiated, `TIMEOUT` is ignored, and WAIT1 waits indefinitely.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run.
  - Required: all outputs 0 at once without a clock edge; `sel`=0.
  - After release, first beat (sync=0, data=1) is ignored with no `sync_err`.
- **Basic frame** (WIDTH=1): beats (sync=1, d=0), then (sync=0, d=1).
  - Required: `out0`=0, `out1`=1, `out_valid` high one cycle, `frame_cnt`=1.
  - Then frame (1,1) gives `out0`=1, `out1`=1, `frame_cnt`=2.
- **Stalls:** (sync=1, d=1), 5 idle cycles, (sync=0, d=0).
  - Required: `sel`=1 through the stall; one `out_valid` with `out0`=1, `out1`=0.
  - With the macro defined and TIMEOUT=16, no `sync_err`.
- **Framing errors:**
  - WAIT1 error: sequence sync=1,1,0 with d=1,0,1 gives `sync_err` on the second beat, then `out0`=0, `out1`=1.
  - WAIT0 error: in WAIT0, beat sync=0 gives `sync_err` and HUNT.
  - In both cases `out0`/`out1` are unchanged by the error.
- **Wrap:** 256 back-to-back frames.
  - Required: `frame_cnt` returns to 0; `out_valid` every second cycle.
- **Timeout** (`M12_DEMUX_TIMEOUT_EN`, TIMEOUT=4): slot 0, then 4 idle cycles.
  - Required: `sync_err` pulse; next beat sync=0 is ignored (HUNT).
  - Without the macro: no pulse, and the next sync=0 beat completes the frame.
